// File: rtl/regfile_sb_pkg.sv
// Shared constants, types and the popcount helper for the scoreboarded register file.
package regfile_sb_pkg;

    localparam int N_DEF   = 32;
    localparam int R_DEF   = 5;
    localparam int NRD_DEF = 2;
    localparam int NWR_DEF = 2;

    // Widest busy vector the popcount helper accepts (address width up to 8).
    localparam int POP_W   = 256;

    typedef logic [R_DEF-1:0] addr_t;
    typedef logic [N_DEF-1:0] word_t;

    function automatic int popcount(input logic [POP_W-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < POP_W; i++) c += int'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/regfile_sb_entry.sv
// One register with its busy flag; resolves write-port priority and reserve-over-clear locally.
module regfile_sb_entry
    import regfile_sb_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int NWR = NWR_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NWR-1:0]   i_we,
    input  logic [NWR*N-1:0] i_wdata,
    input  logic             i_rsv,
    output logic [N-1:0]     o_q,
    output logic             o_busy
);

    logic [N-1:0] r_q;
    logic         r_busy;
    logic [N-1:0] w_d;
    logic         w_we;

    // Ascending scan so the highest enabled port overrides lower ones.
    always_comb begin
        w_we = 1'b0;
        w_d  = r_q;
        for (int j = 0; j < NWR; j++) begin
            if (i_we[j]) begin
                w_we = 1'b1;
                w_d  = i_wdata[j*N +: N];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_busy <= 1'b0;
        end else begin
            if (w_we) r_q <= w_d;
            if (i_rsv)     r_busy <= 1'b1;
            else if (w_we) r_busy <= 1'b0;
        end
    end

    assign o_q    = r_q;
    assign o_busy = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register busy scoreboard; r0 is constant zero.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle writes onto the read ports.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int R   = R_DEF,
    parameter int NRD = NRD_DEF,
    parameter int NWR = NWR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NRD*R-1:0]   rd_addr,
    output logic [NRD*N-1:0]   rd_data,
    output logic [NRD-1:0]     rd_busy,
    input  logic [NWR-1:0]     wr_en,
    input  logic [NWR*R-1:0]   wr_addr,
    input  logic [NWR*N-1:0]   wr_data,
    input  logic               rsv_en,
    input  logic [R-1:0]       rsv_addr,
    output logic [2**R-1:0]    busy_vec,
    output logic [R:0]         busy_cnt
);

    localparam int NREG = 2**R;

    logic [N-1:0] w_regs [NREG];

    assign w_regs[0]   = '0;
    assign busy_vec[0] = 1'b0;

    generate
        for (genvar i = 1; i < NREG; i++) begin : g_ent
            logic [NWR-1:0] w_hit;
            logic           w_rsv;

            for (genvar j = 0; j < NWR; j++) begin : g_hit
                assign w_hit[j] = wr_en[j] && (wr_addr[j*R +: R] == R'(i));
            end
            assign w_rsv = rsv_en && (rsv_addr == R'(i));

            regfile_sb_entry #(.N(N), .NWR(NWR)) u_ent (
                .clk     (clk),
                .rst     (rst),
                .i_we    (w_hit),
                .i_wdata (wr_data),
                .i_rsv   (w_rsv),
                .o_q     (w_regs[i]),
                .o_busy  (busy_vec[i])
            );
        end

        for (genvar k = 0; k < NRD; k++) begin : g_rd
            logic [R-1:0] w_a;
            assign w_a = rd_addr[k*R +: R];

            always_comb begin
                rd_data[k*N +: N] = w_regs[w_a];
                rd_busy[k]        = busy_vec[w_a];
`ifdef REGFILE_SB_BYPASS_EN
                // Forwarded data is final, so it is not busy unless re-reserved this cycle.
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en[j] && (wr_addr[j*R +: R] == w_a) && (w_a != '0)) begin
                        rd_data[k*N +: N] = wr_data[j*N +: N];
                        rd_busy[k]        = rsv_en && (rsv_addr == w_a);
                    end
                end
`endif
            end
        end
    endgenerate

    assign busy_cnt = (R+1)'(popcount(POP_W'(busy_vec)));

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: array model compared every cycle plus literal expectations.
module tb_regfile_sb;

    localparam int N   = 32;
    localparam int R   = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int NREG = 2**R;

    logic               clk;
    logic               rst;
    logic [NRD*R-1:0]   rd_addr;
    logic [NRD*N-1:0]   rd_data;
    logic [NRD-1:0]     rd_busy;
    logic [NWR-1:0]     wr_en;
    logic [NWR*R-1:0]   wr_addr;
    logic [NWR*N-1:0]   wr_data;
    logic               rsv_en;
    logic [R-1:0]       rsv_addr;
    logic [NREG-1:0]    busy_vec;
    logic [R:0]         busy_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    bit [N-1:0] m_mem  [NREG];
    bit         m_busy [NREG];

    regfile_sb #(.N(N), .R(R), .NRD(NRD), .NWR(NWR)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_vec (busy_vec),
        .busy_cnt (busy_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Architectural model: state changes only at an edge, by the stated rules.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wr_addr[j*R +: R] != 0) begin
                    m_mem[wr_addr[j*R +: R]]  = wr_data[j*N +: N];
                    m_busy[wr_addr[j*R +: R]] = 1'b0;
                end
            end
            if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        end
    end

    // Expected view of one read port given the model state and the current inputs.
    task automatic exp_rd(input int a, output logic [N-1:0] d, output logic b);
        d = m_mem[a];
        b = m_busy[a];
`ifdef REGFILE_SB_BYPASS_EN
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && int'(wr_addr[j*R +: R]) == a && a != 0) begin
                d = wr_data[j*N +: N];
                b = rsv_en && int'(rsv_addr) == a;
            end
        end
`endif
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0]    ed;
            logic            eb;
            logic [NREG-1:0] ev;
            int              ec;
            for (int k = 0; k < NRD; k++) begin
                exp_rd(int'(rd_addr[k*R +: R]), ed, eb);
                check($sformatf("model rd_data[%0d] @%0d", k, rd_addr[k*R +: R]), rd_data[k*N +: N], ed);
                check($sformatf("model rd_busy[%0d] @%0d", k, rd_addr[k*R +: R]), 32'(rd_busy[k]), 32'(eb));
            end
            ec = 0;
            for (int i = 0; i < NREG; i++) begin
                ev[i] = m_busy[i];
                ec += int'(m_busy[i]);
            end
            check("model busy_vec", busy_vec, ev);
            check("model busy_cnt", 32'(busy_cnt), 32'(ec));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = '0;
        rsv_en = 1'b0;
    endtask

    task automatic wr(input int p, input int a, input logic [N-1:0] d);
        wr_en[p]          = 1'b1;
        wr_addr[p*R +: R] = R'(a);
        wr_data[p*N +: N] = d;
    endtask

    task automatic rd(input int p, input int a);
        rd_addr[p*R +: R] = R'(a);
    endtask

    task automatic rsv(input int a);
        rsv_en   = 1'b1;
        rsv_addr = R'(a);
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
        idle();
        step(); step();
        rst = 1'b0;
        chk_en = 1'b1;

        // Post-reset sweep across every address on both ports
        for (int a = 0; a < NREG; a++) begin
            rd(0, a); rd(1, NREG-1-a);
            @(negedge clk);
            check("reset rd_data p0", rd_data[0 +: N], 32'h0);
            check("reset rd_data p1", rd_data[N +: N], 32'h0);
            check("reset rd_busy", 32'(rd_busy), 32'h0);
            if (a == 0) begin
                check("reset busy_vec", busy_vec, 32'h0);
                check("reset busy_cnt", 32'(busy_cnt), 32'h0);
            end
            step();
        end

        // r5 write, visible next cycle (or same cycle with forwarding)
        wr(0, 5, 32'hDEADBEEF); rd(0, 5); rd(1, 0);
        @(negedge clk);
`ifdef REGFILE_SB_BYPASS_EN
        check("r5 same-cycle bypass", rd_data[0 +: N], 32'hDEADBEEF);
`else
        check("r5 same-cycle old", rd_data[0 +: N], 32'h0);
`endif
        step(); idle();
        @(negedge clk);
        check("r5 readback", rd_data[0 +: N], 32'hDEADBEEF);

        // Writes to r0 are dropped
        wr(0, 0, 32'h1); rd(1, 0);
        step(); idle();
        @(negedge clk);
        check("r0 stays zero", rd_data[N +: N], 32'h0);

        // Collision: higher port wins
        wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(0, 7);
        step(); idle();
        @(negedge clk);
        check("r7 collision port1 wins", rd_data[0 +: N], 32'h22);

        // Reserve r3
        rsv(3); rd(1, 3);
        step(); idle();
        @(negedge clk);
        check("r3 busy_vec bit", 32'(busy_vec[3]), 32'h1);
        check("r3 busy_cnt", 32'(busy_cnt), 32'h1);
        check("r3 rd_busy", 32'(rd_busy[1]), 32'h1);

        // Re-reserve (WAW) and reserve of r0 are both harmless
        rsv(3);
        step(); rsv(0);
        step(); idle();
        @(negedge clk);
        check("waw/r0 reserve busy_cnt", 32'(busy_cnt), 32'h1);
        check("r0 never busy", 32'(busy_vec[0]), 32'h0);

        // Writeback clears busy
        wr(1, 3, 32'h55);
        step(); idle();
        @(negedge clk);
        check("r3 data", rd_data[N +: N], 32'h55);
        check("r3 cleared busy_cnt", 32'(busy_cnt), 32'h0);
        check("r3 cleared busy_vec", busy_vec, 32'h0);

        // Reserve wins over same-cycle clear
        rsv(9); wr(0, 9, 32'h77); rd(0, 9);
        step(); idle();
        @(negedge clk);
        check("r9 data", rd_data[0 +: N], 32'h77);
        check("r9 busy_vec", busy_vec, 32'h0000_0200);
        check("r9 rd_busy", 32'(rd_busy[0]), 32'h1);

        // Reset discards a pending write and reserve
        rst = 1'b1; wr(1, 9, 32'h1234); rsv(10);
        step(); rst = 1'b0; idle();
        @(negedge clk);
        check("rst r9 cleared", rd_data[0 +: N], 32'h0);
        check("rst busy_vec", busy_vec, 32'h0);
        check("rst busy_cnt", 32'(busy_cnt), 32'h0);

        // Same-cycle read of a write to r4
        wr(0, 4, 32'h1111);
        step(); idle();
        wr(0, 4, 32'hA5A5); rd(1, 4);
        @(negedge clk);
`ifdef REGFILE_SB_BYPASS_EN
        check("r4 bypass data", rd_data[N +: N], 32'hA5A5);
        check("r4 bypass busy", 32'(rd_busy[1]), 32'h0);
`else
        check("r4 old data", rd_data[N +: N], 32'h1111);
`endif
        step(); idle();
        @(negedge clk);
        check("r4 new data", rd_data[N +: N], 32'hA5A5);

        // Reserved r4 being written while read
        rsv(4);
        step(); idle();
        wr(0, 4, 32'hBEEF); rd(1, 4);
        @(negedge clk);
`ifdef REGFILE_SB_BYPASS_EN
        check("r4 fwd clears busy", 32'(rd_busy[1]), 32'h0);
`else
        check("r4 stored busy", 32'(rd_busy[1]), 32'h1);
`endif
        step(); idle();

        // Mixed traffic checked by the model each cycle
        for (int i = 0; i < 48; i++) begin
            idle();
            if (i % 4 == 1 || i % 4 == 3) wr(0, (i*7) % NREG, 32'h0101_0101 * i);
            if (i % 4 >= 2)               wr(1, (i*3+1) % NREG, 32'hF00D_0000 + i);
            if (i % 3 == 0)               rsv((i*5) % NREG);
            rd(0, (i*7) % NREG);
            rd(1, (i*5) % NREG);
            step();
        end
        idle();
        step();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
